// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: OV7670-style DVP transmitter emitting YUV422 test frames.
// PCLK runs at half the system clock; every other pin changes only on the
// clock where PCLK falls, so a receiver sampling on PCLK rising sees stable data.
module cam_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       CLOCK_24,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       PCLK,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] D,
  output logic       busy,
  output logic       frame_done
);

  // Byte periods per line and the counter widths that hold them.
  localparam int LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
  localparam int HREF_BYTES = 2 * H_ACTIVE;
  localparam int BX_W       = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LY_W       = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  // Bar width; small test geometries would otherwise divide by zero.
  localparam int BAR_W      = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

  localparam logic [BX_W-1:0] BX_LAST  = BX_W'(LINE_BYTES - 1);
  localparam logic [BX_W-1:0] HREF_LIM = BX_W'(HREF_BYTES);
  localparam logic [BX_W-1:0] BX_ZERO  = {BX_W{1'b0}};
  localparam logic [BX_W-1:0] BX_ONE   = BX_W'(1);
  localparam logic [LY_W-1:0] LY_ZERO  = {LY_W{1'b0}};
  localparam logic [LY_W-1:0] LY_ONE   = LY_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            ph_r;
  logic [BX_W-1:0] bx_r;
  logic [BX_W-1:0] bx_s;
  logic [LY_W-1:0] ly_r;
  logic [LY_W-1:0] ly_s;
  logic [LY_W-1:0] last_line_s;
  logic [1:0]      mode_r;
  logic [1:0]      mode_s;
  logic [7:0]      frame_cnt_r;
  logic [7:0]      frame_cnt_s;
  logic            done_s;
  logic            vsync_s;
  logic            href_s;
  logic            busy_s;
  logic [7:0]      d_s;

  // Pixel byte for a given line position: Cb, Y(2k), Cr, Y(2k+1) per pair.
  function automatic logic [7:0] pixel_byte(
    input logic [BX_W-1:0] b,
    input logic [LY_W-1:0] line,
    input logic [1:0]      m,
    input logic [7:0]      fc
  );
    int         x_v;
    int         pair_v;
    int         bar_y;
    int         bar_c;
    logic [7:0] luma;
    logic [7:0] cb;
    logic [7:0] cr;
    logic [7:0] res;
    x_v    = int'(b >> 1'b1);
    pair_v = int'(b >> 2'd2) * 32'sd2;
    bar_y  = x_v / BAR_W;
    bar_c  = pair_v / BAR_W;
    case (m)
      2'd0:    luma = 8'(b >> 1'b1);
      2'd1:    luma = 8'(line);
      2'd2:    luma = (bar_y == 32'sd2) ? 8'd145 : 8'(bar_y * 32'sd32 + 32'sd16);
      2'd3:    luma = fc;
      default: luma = fc;
    endcase
    if ((m == 2'd2) && (bar_c == 32'sd2)) begin
      cb = 8'd54;
      cr = 8'd34;
    end else begin
      cb = 8'd128;
      cr = 8'd128;
    end
    case (b[1:0])
      2'b00:   res = cb;
      2'b10:   res = cr;
      default: res = luma;
    endcase
    return res;
  endfunction

  // Index of the final line of the vertical region currently being sent.
  always_comb begin
    last_line_s = LY_ZERO;
    case (state_r)
      ST_VSYNC:  last_line_s = LY_W'(VSYNC_LINES - 1);
      ST_VBACK:  last_line_s = LY_W'(V_BACK - 1);
      ST_ACTIVE: last_line_s = LY_W'(V_ACTIVE - 1);
      ST_VFRONT: last_line_s = LY_W'(V_FRONT - 1);
      default:   last_line_s = LY_ZERO;
    endcase
  end

  // Next state and position; only advances on the PCLK falling boundary.
  always_comb begin
    state_s     = state_r;
    bx_s        = bx_r;
    ly_s        = ly_r;
    mode_s      = mode_r;
    frame_cnt_s = frame_cnt_r;
    done_s      = 1'b0;
    if (ph_r) begin
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            state_s = ST_VSYNC;
            bx_s    = BX_ZERO;
            ly_s    = LY_ZERO;
            mode_s  = mode;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
          if (bx_r != BX_LAST) begin
            bx_s = bx_r + BX_ONE;
          end else begin
            bx_s = BX_ZERO;
            if (ly_r != last_line_s) begin
              ly_s = ly_r + LY_ONE;
            end else begin
              ly_s = LY_ZERO;
              case (state_r)
                ST_VSYNC:  state_s = ST_VBACK;
                ST_VBACK:  state_s = ST_ACTIVE;
                ST_ACTIVE: state_s = ST_VFRONT;
                ST_VFRONT: begin
                  done_s      = 1'b1;
                  frame_cnt_s = frame_cnt_r + 8'd1;
                  // A held request chains straight into the next frame.
                  if (en) begin
                    state_s = ST_VSYNC;
                    mode_s  = mode;
                  end else begin
                    state_s = ST_IDLE;
                  end
                end
                default:   state_s = ST_IDLE;
              endcase
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
          bx_s    = BX_ZERO;
          ly_s    = LY_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Pin values for the byte period that starts at the next edge.
  always_comb begin
    vsync_s = (state_s == ST_VSYNC);
    busy_s  = (state_s != ST_IDLE);
    href_s  = (state_s == ST_ACTIVE) && (bx_s < HREF_LIM);
    if (href_s) begin
      d_s = pixel_byte(bx_s, ly_s, mode_s, frame_cnt_s);
    end else begin
      d_s = 8'd0;
    end
  end

  // Phase, FSM, counters and registered pin outputs.
  always_ff @(posedge CLOCK_24) begin
    if (rst) begin
      ph_r        <= 1'b0;
      state_r     <= ST_IDLE;
      bx_r        <= BX_ZERO;
      ly_r        <= LY_ZERO;
      mode_r      <= 2'd0;
      frame_cnt_r <= 8'd0;
      VSYNC       <= 1'b0;
      HREF        <= 1'b0;
      D           <= 8'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      ph_r        <= ~ph_r;
      state_r     <= state_s;
      bx_r        <= bx_s;
      ly_r        <= ly_s;
      mode_r      <= mode_s;
      frame_cnt_r <= frame_cnt_s;
      VSYNC       <= vsync_s;
      HREF        <= href_s;
      D           <= d_s;
      busy        <= busy_s;
      frame_done  <= done_s;
    end
  end

  assign PCLK = ph_r;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Self-checking bench for cam_pattern_gen on a reduced frame geometry.
module tb_cam_pattern_gen;

  localparam int HA = 16;
  localparam int HB = 4;
  localparam int VA = 4;
  localparam int VL = 2;
  localparam int VB = 1;
  localparam int VF = 2;
  localparam int LINE_BYTES  = 2 * (HA + HB);
  localparam int FRAME_LINES = VL + VB + VA + VF;
  localparam int FRAME_BYTES = LINE_BYTES * FRAME_LINES;
  localparam int BAR_W       = HA / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] D;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int fc_model = 0;

  cam_pattern_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VL), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .CLOCK_24(clk), .rst(rst), .en(en), .mode(mode),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Free-running cycle count for frame-length measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something upstream never terminates.
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // Pin bundle: {PCLK, VSYNC, HREF, D, busy, frame_done}.
  function automatic logic [12:0] pins();
    return {PCLK, VSYNC, HREF, D, busy, frame_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: expected pins mid byte period for line li, byte b of a frame.
  function automatic logic [12:0] exp_sample(input int li, input int b, input int m, input int fc);
    bit vs;
    bit hr;
    int y;
    int x;
    int role;
    int bar;
    int d;
    vs = (li < VL);
    y  = li - (VL + VB);
    hr = (y >= 0) && (y < VA) && (b < 2 * HA);
    d  = 0;
    if (hr) begin
      x    = b / 2;
      role = b % 4;
      if (role == 1 || role == 3) begin
        case (m)
          0: d = x % 256;
          1: d = y % 256;
          2: begin
            bar = x / BAR_W;
            d = (bar == 2) ? 145 : (32 * bar + 16) % 256;
          end
          default: d = fc % 256;
        endcase
      end else begin
        bar = (x - (x % 2)) / BAR_W;
        if (m == 2 && bar == 2) d = (role == 0) ? 54 : 34;
        else d = 128;
      end
    end
    return {1'b1, vs, hr, 8'(d), 1'b1, 1'b0};
  endfunction

  // Raise en (with mode) at a negedge and check VSYNC latency.
  task automatic start_frame(input logic [1:0] m);
    int exp_wait;
    int n;
    mode = m;
    en = 1'b1;
    exp_wait = (PCLK === 1'b1) ? 1 : 2;
    n = 0;
    while (VSYNC !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("vsync_latency", n, exp_wait);
  endtask

  // Check one whole frame byte by byte, plus its end boundary.
  task automatic check_frame(input int drop_en_at, input int chg_mode_at, input logic [1:0] chg_val);
    int n;
    int t0;
    int m_exp;
    n = 0;
    while (VSYNC !== 1'b1 && n < 4 * FRAME_BYTES) begin
      @(negedge clk);
      n++;
    end
    check("vsync_start", 32'(VSYNC), 32'd1);
    if (VSYNC !== 1'b1) return;
    t0 = cyc;
    m_exp = int'(mode);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      @(negedge clk);
      if (i == drop_en_at) en = 1'b0;
      if (i == chg_mode_at) mode = chg_val;
      check("frame_byte", 32'(pins()),
            32'(exp_sample(i / LINE_BYTES, i % LINE_BYTES, m_exp, fc_model)));
      if (i != FRAME_BYTES - 1) @(negedge clk);
    end
    @(negedge clk);
    fc_model = (fc_model + 1) % 256;
    check("frame_clocks", cyc - t0, 2 * FRAME_BYTES);
    check("frame_end", 32'(pins()), 32'({1'b0, en, 1'b0, 8'd0, en, 1'b1}));
    if (en !== 1'b1) begin
      @(negedge clk);
      check("done_width", 32'(pins()), 32'({1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_pins", 32'(pins()), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pclk_toggle", 32'(PCLK), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4 * LINE_BYTES; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({VSYNC, HREF, D, busy, frame_done}), 32'd0);
    end

    // Ramp frame from an en pulse.
    start_frame(2'd0);
    en = 1'b0;
    check_frame(-1, -1, 2'd0);

    // Line-index frame.
    start_frame(2'd1);
    en = 1'b0;
    check_frame(-1, -1, 2'd0);

    // Frame counter pattern back-to-back; en dropped inside frame 2.
    start_frame(2'd3);
    check_frame(-1, -1, 2'd0);
    check_frame($urandom_range(1, FRAME_BYTES - 2), -1, 2'd0);

    // Mode changed mid-frame takes effect on the chained frame only.
    start_frame(2'd0);
    check_frame(-1, $urandom_range(10, FRAME_BYTES - 10), 2'd2);
    check_frame($urandom_range(1, FRAME_BYTES - 2), -1, 2'd0);

    // Random single frames.
    for (int k = 0; k < 3; k++) begin
      start_frame(2'($urandom_range(0, 3)));
      en = 1'b0;
      check_frame(-1, -1, 2'd0);
    end

    // Reset in the middle of a frame.
    start_frame(2'($urandom_range(0, 3)));
    en = 1'b0;
    n = $urandom_range(50, FRAME_BYTES);
    repeat (n) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midframe_reset", 32'(pins()), 32'd0);
    end
    rst = 1'b0;
    fc_model = 0;
    for (int i = 0; i < 2 * LINE_BYTES; i++) begin
      @(negedge clk);
      check("post_reset_quiet", 32'({VSYNC, HREF, D, busy, frame_done}), 32'd0);
    end
    start_frame(2'd3);
    en = 1'b0;
    check_frame(-1, -1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
